// File: rtl/comma_ser.sv
// comma_ser: turns 1/2/4-byte values (or a pad-to-4 request) into little-endian
// single-byte writes for the comma stage, advancing HERE once per accepted byte.
module comma_ser #(
    parameter int DSZ = 8,
    parameter int ASZ = 17,
    parameter int WSZ = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           set_here,
    input  logic [ASZ-1:0] here_i,
    input  logic           req,
    input  logic [1:0]     sz,
    input  logic [WSZ-1:0] vi,
    output logic           rdy,
    output logic           done,
    output logic [ASZ-1:0] here_o,
    output logic           cm_en,
    output logic [ASZ-1:0] cm_ai,
    output logic [DSZ-1:0] cm_vi,
    input  logic           cm_ack,
    output logic           st
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t         state;
    logic [ASZ-1:0] here;
    logic [WSZ-1:0] val;
    logic [2:0]     cnt;
    logic [1:0]     pad;
    logic [2:0]     nbytes;
    logic           accept;

    // Bytes needed to reach the next 4-byte boundary: (4 - here[1:0]) mod 4.
    assign pad    = 2'd0 - here[1:0];
    assign rdy    = (state == IDLE) && !set_here;
    assign accept = req && rdy;

    always_comb begin
        nbytes = 3'd1;
        case (sz)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            2'd2:    nbytes = 3'd4;
            default: nbytes = {1'b0, pad};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            here  <= '0;
            val   <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (set_here) begin
                        here <= here_i;
                    end else if (accept) begin
                        val <= (sz == 2'd3) ? '0 : vi;
                        cnt <= nbytes;
                        // An already-aligned pad request has nothing to emit.
                        if (nbytes == 3'd0) begin
                            done <= 1'b1;
                        end else begin
                            state <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (cm_ack) begin
                        here <= here + ASZ'(1);
                        val  <= val >> DSZ;
                        cnt  <= cnt - 3'd1;
                        if (cnt == 3'd1) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign here_o = here;
    assign cm_en  = (state == EMIT);
    assign cm_ai  = here;
    assign cm_vi  = val[DSZ-1:0];
    assign st     = state;

endmodule

// File: tb/tb_comma_ser.sv
// Directed-vector bench for comma_ser: each task drives one scenario and
// checks outputs #1 after the rising edge against hand-computed values.
module tb_comma_ser;

    logic        clk;
    logic        rst_n;
    logic        set_here;
    logic [16:0] here_i;
    logic        req;
    logic [1:0]  sz;
    logic [31:0] vi;
    logic        rdy;
    logic        done;
    logic [16:0] here_o;
    logic        cm_en;
    logic [16:0] cm_ai;
    logic [7:0]  cm_vi;
    logic        cm_ack;
    logic        st;

    int vectors = 0;
    int miscompares = 0;

    comma_ser #(.DSZ(8), .ASZ(17), .WSZ(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_here (set_here),
        .here_i   (here_i),
        .req      (req),
        .sz       (sz),
        .vi       (vi),
        .rdy      (rdy),
        .done     (done),
        .here_o   (here_o),
        .cm_en    (cm_en),
        .cm_ai    (cm_ai),
        .cm_vi    (cm_vi),
        .cm_ack   (cm_ack),
        .st       (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (here_o !== 17'h0) begin miscompares++; $display("[TB] FAIL reset_here: got %h expected %h", here_o, 17'h0); end
        vectors++; if (cm_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cm_en: got %b expected 0", cm_en); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        vectors++; if (cm_vi !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_cm_vi: got %h expected 00", cm_vi); end
        vectors++; if (cm_ai !== 17'h0) begin miscompares++; $display("[TB] FAIL reset_cm_ai: got %h expected 0", cm_ai); end
        vectors++; if (st !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_st: got %b expected 0", st); end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_rdy: got %b expected 1", rdy); end
        // ack with nothing pending must not move HERE
        cm_ack = 1'b1;
        tick();
        tick();
        vectors++; if (here_o !== 17'h0) begin miscompares++; $display("[TB] FAIL idle_ack_here: got %h expected %h", here_o, 17'h0); end
        vectors++; if (cm_en !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_ack_cm_en: got %b expected 0", cm_en); end
        cm_ack = 1'b0;
    endtask

    task automatic test_word();
        logic [7:0]  eb [4];
        logic [16:0] ea;
        eb = '{8'h44, 8'h33, 8'h22, 8'h11};
        set_here = 1'b1; here_i = 17'h00100;
        #1;
        vectors++; if (rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL word_rdy_set: got %b expected 0", rdy); end
        tick();
        set_here = 1'b0;
        req = 1'b1; sz = 2'd2; vi = 32'h11223344; cm_ack = 1'b1;
        #1;
        vectors++; if (here_o !== 17'h00100) begin miscompares++; $display("[TB] FAIL word_here_load: got %h expected %h", here_o, 17'h00100); end
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL word_rdy: got %b expected 1", rdy); end
        tick();
        req = 1'b0; vi = 32'hFFFFFFFF;
        ea = 17'h00100;
        for (int i = 0; i < 4; i++) begin
            vectors++; if (cm_en !== 1'b1) begin miscompares++; $display("[TB] FAIL word_cm_en[%0d]: got %b expected 1", i, cm_en); end
            vectors++; if (cm_ai !== ea) begin miscompares++; $display("[TB] FAIL word_addr[%0d]: got %h expected %h", i, cm_ai, ea); end
            vectors++; if (cm_vi !== eb[i]) begin miscompares++; $display("[TB] FAIL word_byte[%0d]: got %h expected %h", i, cm_vi, eb[i]); end
            vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL word_early_done[%0d]: got %b expected 0", i, done); end
            ea = ea + 17'd1;
            tick();
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL word_done: got %b expected 1", done); end
        vectors++; if (here_o !== 17'h00104) begin miscompares++; $display("[TB] FAIL word_here_end: got %h expected %h", here_o, 17'h00104); end
        vectors++; if (cm_en !== 1'b0) begin miscompares++; $display("[TB] FAIL word_cm_en_end: got %b expected 0", cm_en); end
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL word_rdy_done: got %b expected 1", rdy); end
        tick();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL word_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_align();
        logic [16:0] ea;
        // HERE=0x101 needs three pad bytes
        set_here = 1'b1; here_i = 17'h00101;
        tick();
        set_here = 1'b0; req = 1'b1; sz = 2'd3; vi = 32'hFFFFFFFF; cm_ack = 1'b1;
        tick();
        req = 1'b0;
        ea = 17'h00101;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (cm_en !== 1'b1) begin miscompares++; $display("[TB] FAIL pad3_cm_en[%0d]: got %b expected 1", i, cm_en); end
            vectors++; if (cm_ai !== ea) begin miscompares++; $display("[TB] FAIL pad3_addr[%0d]: got %h expected %h", i, cm_ai, ea); end
            vectors++; if (cm_vi !== 8'h00) begin miscompares++; $display("[TB] FAIL pad3_byte[%0d]: got %h expected 00", i, cm_vi); end
            ea = ea + 17'd1;
            tick();
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL pad3_done: got %b expected 1", done); end
        vectors++; if (here_o !== 17'h00104) begin miscompares++; $display("[TB] FAIL pad3_here: got %h expected %h", here_o, 17'h00104); end
        tick();
        // HERE=0x103 needs one pad byte
        set_here = 1'b1; here_i = 17'h00103;
        tick();
        set_here = 1'b0; req = 1'b1; sz = 2'd3;
        tick();
        req = 1'b0;
        vectors++; if (cm_en !== 1'b1) begin miscompares++; $display("[TB] FAIL pad1_cm_en: got %b expected 1", cm_en); end
        vectors++; if (cm_ai !== 17'h00103) begin miscompares++; $display("[TB] FAIL pad1_addr: got %h expected %h", cm_ai, 17'h00103); end
        vectors++; if (cm_vi !== 8'h00) begin miscompares++; $display("[TB] FAIL pad1_byte: got %h expected 00", cm_vi); end
        tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL pad1_done: got %b expected 1", done); end
        vectors++; if (here_o !== 17'h00104) begin miscompares++; $display("[TB] FAIL pad1_here: got %h expected %h", here_o, 17'h00104); end
        vectors++; if (cm_en !== 1'b0) begin miscompares++; $display("[TB] FAIL pad1_cm_en_end: got %b expected 0", cm_en); end
        // already aligned: done next cycle, nothing emitted
        req = 1'b1; sz = 2'd3;
        tick();
        req = 1'b0;
        vectors++; if (cm_en !== 1'b0) begin miscompares++; $display("[TB] FAIL pad0_cm_en: got %b expected 0", cm_en); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL pad0_done: got %b expected 1", done); end
        vectors++; if (here_o !== 17'h00104) begin miscompares++; $display("[TB] FAIL pad0_here: got %h expected %h", here_o, 17'h00104); end
        vectors++; if (st !== 1'b0) begin miscompares++; $display("[TB] FAIL pad0_st: got %b expected 0", st); end
        tick();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL pad0_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_wrap();
        set_here = 1'b1; here_i = 17'h1FFFF;
        tick();
        set_here = 1'b0; req = 1'b1; sz = 2'd1; vi = 32'h5555ABCD; cm_ack = 1'b1;
        tick();
        req = 1'b0;
        vectors++; if (cm_ai !== 17'h1FFFF) begin miscompares++; $display("[TB] FAIL wrap_addr0: got %h expected %h", cm_ai, 17'h1FFFF); end
        vectors++; if (cm_vi !== 8'hCD) begin miscompares++; $display("[TB] FAIL wrap_byte0: got %h expected CD", cm_vi); end
        tick();
        vectors++; if (cm_ai !== 17'h00000) begin miscompares++; $display("[TB] FAIL wrap_addr1: got %h expected %h", cm_ai, 17'h00000); end
        vectors++; if (cm_vi !== 8'hAB) begin miscompares++; $display("[TB] FAIL wrap_byte1: got %h expected AB", cm_vi); end
        vectors++; if (cm_en !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_cm_en1: got %b expected 1", cm_en); end
        tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_done: got %b expected 1", done); end
        vectors++; if (here_o !== 17'h00001) begin miscompares++; $display("[TB] FAIL wrap_here: got %h expected %h", here_o, 17'h00001); end
        vectors++; if (cm_en !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_cm_en_end: got %b expected 0", cm_en); end
        tick();
    endtask

    task automatic test_stall();
        logic [7:0]  eb [4];
        logic        pat [7];
        int          k;
        eb  = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        set_here = 1'b1; here_i = 17'h00200;
        tick();
        set_here = 1'b0; req = 1'b1; sz = 2'd2; vi = 32'hDEADBEEF; cm_ack = 1'b0;
        tick();
        req = 1'b0;
        k = 0;
        for (int i = 0; i < 7; i++) begin
            cm_ack = pat[i];
            // set_here during EMIT must be ignored
            set_here = (i == 1); here_i = 17'h01234;
            #1;
            vectors++; if (cm_en !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_cm_en[%0d]: got %b expected 1", i, cm_en); end
            vectors++; if (cm_vi !== eb[k]) begin miscompares++; $display("[TB] FAIL stall_byte[%0d]: got %h expected %h", i, cm_vi, eb[k]); end
            vectors++; if (cm_ai !== 17'h00200 + 17'(k)) begin miscompares++; $display("[TB] FAIL stall_addr[%0d]: got %h expected %h", i, cm_ai, 17'h00200 + 17'(k)); end
            vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_early_done[%0d]: got %b expected 0", i, done); end
            if (pat[i]) k++;
            @(posedge clk);
            #0;
        end
        set_here = 1'b0;
        #1;
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_done: got %b expected 1", done); end
        vectors++; if (here_o !== 17'h00204) begin miscompares++; $display("[TB] FAIL stall_here: got %h expected %h", here_o, 17'h00204); end
        vectors++; if (cm_en !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_cm_en_end: got %b expected 0", cm_en); end
        cm_ack = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        set_here = 1'b1; here_i = 17'h00010;
        tick();
        set_here = 1'b0; req = 1'b1; sz = 2'd0; vi = 32'h123456A5; cm_ack = 1'b1;
        tick();
        // req stays high during EMIT and vi changes: both must be ignored
        vi = 32'h00000077;
        #1;
        vectors++; if (cm_vi !== 8'hA5) begin miscompares++; $display("[TB] FAIL b2b_byte0: got %h expected A5", cm_vi); end
        vectors++; if (cm_ai !== 17'h00010) begin miscompares++; $display("[TB] FAIL b2b_addr0: got %h expected %h", cm_ai, 17'h00010); end
        vectors++; if (rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_rdy_emit: got %b expected 0", rdy); end
        tick();
        vi = 32'h0000005A;
        #1;
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_done0: got %b expected 1", done); end
        vectors++; if (rdy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_rdy_done: got %b expected 1", rdy); end
        tick();
        req = 1'b0;
        vectors++; if (cm_en !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_cm_en1: got %b expected 1", cm_en); end
        vectors++; if (cm_vi !== 8'h5A) begin miscompares++; $display("[TB] FAIL b2b_byte1: got %h expected 5A", cm_vi); end
        vectors++; if (cm_ai !== 17'h00011) begin miscompares++; $display("[TB] FAIL b2b_addr1: got %h expected %h", cm_ai, 17'h00011); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_done_gap: got %b expected 0", done); end
        tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_done1: got %b expected 1", done); end
        vectors++; if (here_o !== 17'h00012) begin miscompares++; $display("[TB] FAIL b2b_here: got %h expected %h", here_o, 17'h00012); end
        tick();
    endtask

    task automatic test_reset_mid();
        set_here = 1'b1; here_i = 17'h00300;
        tick();
        set_here = 1'b0; req = 1'b1; sz = 2'd2; vi = 32'h01020304; cm_ack = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        vectors++; if (cm_vi !== 8'h02) begin miscompares++; $display("[TB] FAIL rmid_byte2: got %h expected 02", cm_vi); end
        vectors++; if (here_o !== 17'h00302) begin miscompares++; $display("[TB] FAIL rmid_here2: got %h expected %h", here_o, 17'h00302); end
        rst_n = 1'b0;
        #1;
        vectors++; if (cm_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_cm_en: got %b expected 0", cm_en); end
        vectors++; if (here_o !== 17'h0) begin miscompares++; $display("[TB] FAIL rmid_here: got %h expected %h", here_o, 17'h0); end
        vectors++; if (st !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_st: got %b expected 0", st); end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_no_done: got %b expected 0", done); end
        req = 1'b1; sz = 2'd0; vi = 32'h00000099;
        tick();
        req = 1'b0;
        vectors++; if (cm_vi !== 8'h99) begin miscompares++; $display("[TB] FAIL rmid_new_byte: got %h expected 99", cm_vi); end
        vectors++; if (cm_ai !== 17'h0) begin miscompares++; $display("[TB] FAIL rmid_new_addr: got %h expected %h", cm_ai, 17'h0); end
        tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_new_done: got %b expected 1", done); end
        vectors++; if (here_o !== 17'h00001) begin miscompares++; $display("[TB] FAIL rmid_new_here: got %h expected %h", here_o, 17'h00001); end
        tick();
    endtask

    task automatic test_set_and_req();
        set_here = 1'b1; here_i = 17'h00040; req = 1'b1; sz = 2'd0; vi = 32'h00000055; cm_ack = 1'b1;
        #1;
        vectors++; if (rdy !== 1'b0) begin miscompares++; $display("[TB] FAIL setreq_rdy: got %b expected 0", rdy); end
        tick();
        vectors++; if (here_o !== 17'h00040) begin miscompares++; $display("[TB] FAIL setreq_here: got %h expected %h", here_o, 17'h00040); end
        vectors++; if (cm_en !== 1'b0) begin miscompares++; $display("[TB] FAIL setreq_not_taken: got %b expected 0", cm_en); end
        set_here = 1'b0;
        tick();
        req = 1'b0;
        vectors++; if (cm_en !== 1'b1) begin miscompares++; $display("[TB] FAIL setreq_cm_en: got %b expected 1", cm_en); end
        vectors++; if (cm_ai !== 17'h00040) begin miscompares++; $display("[TB] FAIL setreq_addr: got %h expected %h", cm_ai, 17'h00040); end
        vectors++; if (cm_vi !== 8'h55) begin miscompares++; $display("[TB] FAIL setreq_byte: got %h expected 55", cm_vi); end
        tick();
        vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL setreq_done: got %b expected 1", done); end
        vectors++; if (here_o !== 17'h00041) begin miscompares++; $display("[TB] FAIL setreq_here_end: got %h expected %h", here_o, 17'h00041); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; set_here = 1'b0; here_i = '0; req = 1'b0;
        sz = 2'd0; vi = '0; cm_ack = 1'b0;
        test_reset();
        test_word();
        test_align();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_set_and_req();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not reach the end of the test sequence");
        $fatal(1, "[TB] timeout");
    end

endmodule
